// File: rtl/div_unit_32bit.sv
// div_unit_32bit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle using an (N+1)-bit trial subtraction, with a
// start/busy/valid handshake.
// Optional feature macro: DIV_EARLY_OUT_EN -- zero divisor and signed overflow
// complete straight from IDLE to DONE instead of iterating.
module div_unit_32bit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_result,
  output logic         o_div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [1:0]    op;
  logic [N-1:0]  a_orig;
  logic [N-1:0]  dvsr;
  logic [N-1:0]  quo;
  logic [N-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic          sign_r;
  logic          zero_l;
  logic          ovf_l;
  logic [N-1:0]  result_q;
  logic          dbz_q;
  logic          valid_q;

  logic          signed_op;
  logic [N-1:0]  abs_a;
  logic [N-1:0]  abs_b;
  logic          in_zero;
  logic          in_ovf;
  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;
  logic [N-1:0]  res_fix;

  // Operand conditioning at accept: magnitudes and special-case detection
  always_comb begin
    signed_op = ~i_op[0];
    abs_a     = (signed_op && i_a[N-1]) ? (~i_a + 1'b1) : i_a;
    abs_b     = (signed_op && i_b[N-1]) ? (~i_b + 1'b1) : i_b;
    in_zero   = (i_b == '0);
    in_ovf    = (i_op == 2'b00) && (i_a == MIN_NEG) && (i_b == '1);
  end

  // Shift-in of the next dividend bit and trial subtraction
  always_comb begin
    rem_sh = {rem, quo[N-1]};
    trial  = rem_sh - {1'b0, dvsr};
  end

  // Final sign correction and special-case overrides
  always_comb begin
    q_fin = sign_q ? (~quo + 1'b1) : quo;
    r_fin = sign_r ? (~rem + 1'b1) : rem;
    if (zero_l)
      res_fix = op[1] ? a_orig : '1;
    else if (ovf_l)
      res_fix = op[1] ? '0 : MIN_NEG;
    else
      res_fix = op[1] ? r_fin : q_fin;
  end

`ifdef DIV_EARLY_OUT_EN
  logic [N-1:0] res_early;

  // Same values FIX would produce for the special cases, taken from the inputs
  always_comb begin
    if (in_zero)
      res_early = i_op[1] ? i_a : '1;
    else
      res_early = i_op[1] ? '0 : MIN_NEG;
  end
`endif

  // Divider FSM and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      op       <= '0;
      a_orig   <= '0;
      dvsr     <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_l   <= 1'b0;
      ovf_l    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            op     <= i_op;
            a_orig <= i_a;
            dvsr   <= abs_b;
            quo    <= abs_a;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= signed_op & (i_a[N-1] ^ i_b[N-1]);
            sign_r <= signed_op & i_a[N-1];
            zero_l <= in_zero;
            ovf_l  <= in_ovf;
            state  <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
            if (in_zero || in_ovf) begin
              result_q <= res_early;
              dbz_q    <= in_zero;
              state    <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          // quo doubles as the dividend shifter: its MSB feeds rem each step
          rem <= trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
          quo <= {quo[N-2:0], ~trial[N]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER)
            state <= S_FIX;
        end
        S_FIX: begin
          result_q <= res_fix;
          dbz_q    <= zero_l;
          state    <= S_DONE;
        end
        default: begin
          valid_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = (state != S_IDLE);
  assign o_valid       = valid_q;
  assign o_result      = result_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// tb_div_unit_32bit: directed self-checking bench for div_unit_32bit.
module tb_div_unit_32bit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_div_by_zero;

  int checks = 0;
  int errors = 0;

  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = 34;
`endif

  div_unit_32bit #(.N(32)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .o_result      (o_result),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance edge by edge (sampling 1ns after each) until o_valid, bounded
  task automatic wait_valid(input int lat0, output int lat, output logic seen);
    lat  = lat0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge i_clk); #1;
      lat++;
      seen = o_valid;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic edbz,
                        input int elat);
    int   lat;
    logic seen;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_a = $urandom; i_b = $urandom; i_op = 2'($urandom_range(0, 3));
    check({tag, " busy"}, 64'(o_busy), 64'd1);
    wait_valid(0, lat, seen);
    check({tag, " valid"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " result"}, 64'(o_result), 64'(er));
    check({tag, " dbz"}, 64'(o_div_by_zero), 64'(edbz));
    check({tag, " idle at valid"}, 64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
    check({tag, " valid width"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    int   pulses;
    int   wide;
    int   p [3];
    logic prev;

    i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset valid", 64'(o_valid), 64'd0);
    check("reset result", 64'(o_result), 64'd0);
    check("reset dbz", 64'(o_div_by_zero), 64'd0);
    i_reset = 1'b0;

    run_op("divu 100/7",      2'b01, 32'd100,        32'd7,          32'd14,         1'b0, LAT);
    run_op("remu 100/7",      2'b11, 32'd100,        32'd7,          32'd2,          1'b0, LAT);
    run_op("div -7/2",        2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, LAT);
    run_op("rem -7/2",        2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, LAT);
    run_op("rem 7/-2",        2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, LAT);
    run_op("div 7/-2",        2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, LAT);
    run_op("div ovf",         2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, EXC_LAT);
    run_op("rem ovf",         2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, EXC_LAT);
    run_op("divu min/-1",     2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, LAT);
    run_op("remu min/-1",     2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, LAT);
    run_op("divu 5/0",        2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, EXC_LAT);
    run_op("rem -5/0",        2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, EXC_LAT);
    run_op("div -5/0",        2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, EXC_LAT);
    run_op("div min/2",       2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, LAT);
    run_op("div hex/16",      2'b00, 32'h1234_5678,  32'h10,         32'h0123_4567,  1'b0, LAT);
    run_op("remu hex/16",     2'b11, 32'h1234_5678,  32'h10,         32'd8,          1'b0, LAT);
    run_op("divu max/max",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, LAT);
    run_op("divu max/1",      2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, LAT);

    // start pulse during CALC must be ignored
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge i_clk); #1; lat++; end
    i_start = 1'b1; i_op = 2'b00; i_a = 32'd1000; i_b = 32'd3;
    @(posedge i_clk); #1; lat++;
    i_start = 1'b0;
    wait_valid(lat, lat, seen);
    check("ignore valid", 64'(seen), 64'd1);
    check("ignore latency", 64'(lat), 64'(LAT));
    check("ignore result", 64'(o_result), 64'd14);
    repeat (3) @(posedge i_clk);
    #1;
    check("ignore no 2nd op", 64'(o_busy), 64'd0);

    // reset mid-operation aborts with no valid
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort result", 64'(o_result), 64'd0);
    check("abort dbz", 64'(o_div_by_zero), 64'd0);
    check("abort valid", 64'(o_valid), 64'd0);
    i_reset = 1'b0;
    pulses = 0;
    repeat (40) begin @(posedge i_clk); #1; if (o_valid) pulses++; end
    check("abort no valid", 64'(pulses), 64'd0);

    // reset wins over start on the same edge
    @(negedge i_clk);
    i_reset = 1'b1; i_start = 1'b1; i_op = 2'b01; i_a = 32'd9; i_b = 32'd3;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_start = 1'b0;
    check("reset priority busy", 64'(o_busy), 64'd0);

    // back-to-back with start held high
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    pulses = 0; wide = 0; prev = 1'b0;
    p[0] = 0; p[1] = 0; p[2] = 0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        if (prev) wide++;
        else begin
          if (pulses < 3) p[pulses] = cyc;
          pulses++;
        end
      end
      prev = o_valid;
    end
    i_start = 1'b0;
    check("b2b pulse count", 64'(pulses), 64'd3);
    check("b2b first", 64'(p[0]), 64'(LAT));
    check("b2b gap1", 64'(p[1] - p[0]), 64'd35);
    check("b2b gap2", 64'(p[2] - p[1]), 64'd35);
    check("b2b width", 64'(wide), 64'd0);
    check("b2b result", 64'(o_result), 64'd14);
    repeat (40) @(posedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
